// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// ALU operations and FSM state codes (visible to the bench for state probing).
package multicycle_ctrl_pkg;

  localparam logic [5:0] OPCODE_R    = 6'h00;
  localparam logic [5:0] OPCODE_J    = 6'h02;
  localparam logic [5:0] OPCODE_BEQ  = 6'h04;
  localparam logic [5:0] OPCODE_ADDI = 6'h08;
  localparam logic [5:0] OPCODE_ORI  = 6'h0D;
  localparam logic [5:0] OPCODE_LW   = 6'h23;
  localparam logic [5:0] OPCODE_SW   = 6'h2B;

  localparam logic [5:0] FUNCT_NOP  = 6'h00;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  localparam logic [2:0] ALU_NOP  = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd6;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EX_R    = 4'd2;
  localparam logic [3:0] S_EX_I    = 4'd3;
  localparam logic [3:0] S_MEM_ADR = 4'd4;
  localparam logic [3:0] S_MEM_RD  = 4'd5;
  localparam logic [3:0] S_MEM_WR  = 4'd6;
  localparam logic [3:0] S_WB_ALU  = 4'd7;
  localparam logic [3:0] S_WB_MEM  = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;
  localparam logic [3:0] S_ERR     = 4'd11;

  // States that hold an outstanding memory access and run the wait counter.
  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// R-type funct to ALU operation decode; flags functs the controller does not support.
module mc_alu_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       illegal_funct
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    alu_op        = ALU_NOP;
    illegal_funct = 1'b0;
    case (funct)
      FUNCT_ADD, FUNCT_ADDU: alu_op = ALU_ADD;
      FUNCT_SUB, FUNCT_SUBU: alu_op = ALU_SUB;
      FUNCT_AND:             alu_op = ALU_AND;
      FUNCT_OR:              alu_op = ALU_OR;
      FUNCT_SLT:             alu_op = ALU_SLT;
      FUNCT_SLTU:            alu_op = ALU_SLTU;
      FUNCT_NOP:             alu_op = ALU_NOP;
      default:               illegal_funct = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory, with a bounded wait on every memory access.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 255,
  parameter int unsigned WAIT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic [1:0]  PCSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        instr_done,
  output logic        illegal
);

  logic [3:0]        state;
  logic [3:0]        state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [5:0]        opcode;
  logic [2:0]        funct_op;
  logic              funct_bad;
  logic              waiting;
  logic              timeout;
  logic              unused_bits;

  assign opcode = inst[31:26];
  // The zero flag gates PCWriteCond in the datapath; register fields are not decoded here.
  assign unused_bits = ^{zero, inst[25:6]};

  mc_alu_decode u_alu_decode (
    .funct         (inst[5:0]),
    .alu_op        (funct_op),
    .illegal_funct (funct_bad)
  );

  assign waiting = is_mem_state(state) && !mem_ready;
  // A cycle with mem_ready never times out, even when the count has run out.
  assign timeout = (MEM_WAIT_MAX != 0) && waiting &&
                   (wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1));
  assign illegal = (state == S_ERR);

  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSrc       = 2'd0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOp       = ALU_NOP;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    instr_done  = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'd1;
        ALUOp   = ALU_ADD;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_ERR;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'd3;
        ALUOp   = ALU_ADD;
        case (opcode)
          OPCODE_R:                state_next = S_EX_R;
          OPCODE_ADDI, OPCODE_ORI: state_next = S_EX_I;
          OPCODE_LW, OPCODE_SW:    state_next = S_MEM_ADR;
          OPCODE_BEQ:              state_next = S_BRANCH;
          OPCODE_J:                state_next = S_JUMP;
          default:                 state_next = S_ERR;
        endcase
      end
      S_EX_R: begin
        ALUSrcA    = 1'b1;
        ALUOp      = funct_op;
        state_next = funct_bad ? S_ERR : S_WB_ALU;
      end
      S_EX_I: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'd2;
        ALUOp      = (opcode == OPCODE_ORI) ? ALU_OR : ALU_ADD;
        state_next = S_WB_ALU;
      end
      S_WB_ALU: begin
        RegWrite   = 1'b1;
        RegDst     = (opcode == OPCODE_R);
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_ADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'd2;
        ALUOp      = ALU_ADD;
        state_next = (opcode == OPCODE_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)    state_next = S_WB_MEM;
        else if (timeout) state_next = S_ERR;
      end
      S_WB_MEM: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else if (timeout) begin
          state_next = S_ERR;
        end
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSrc       = 2'd1;
        instr_done  = 1'b1;
        state_next  = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'd2;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_ERR:   state_next = S_ERR;
      default: state_next = S_ERR;
    endcase
    // Reset abandons any outstanding access and suppresses every enable at once.
    if (rst) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      RegWrite    = 1'b0;
      instr_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (waiting && (state_next == state)) wait_cnt <= wait_cnt + 1'b1;
      else                                  wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction traces, random
// instruction streams with random memory waits, error/timeout and reset cases.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_J} kind_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = '0;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic        mem_req, mem_we, IorD, IRWrite, PCWrite, PCWriteCond;
  logic [1:0]  PCSrc, ALUSrcB;
  logic        ALUSrcA, RegDst, MemtoReg, RegWrite, instr_done, illegal;
  logic [2:0]  ALUOp;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] st_q[$];

  multicycle_ctrl #(.MEM_WAIT_MAX(4), .WAIT_W(3)) dut (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .instr_done(instr_done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enables();
    return 32'({IRWrite, PCWrite, PCWriteCond, RegWrite, instr_done});
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return ALU_ADD;
      6'h22, 6'h23: return ALU_SUB;
      6'h24:        return ALU_AND;
      6'h25:        return ALU_OR;
      6'h2A:        return ALU_SLT;
      6'h2B:        return ALU_SLTU;
      default:      return ALU_NOP;
    endcase
  endfunction

  function automatic kind_t kind_of(input logic [31:0] ins);
    case (ins[31:26])
      6'h00:        return K_R;
      6'h08, 6'h0D: return K_I;
      6'h23:        return K_LW;
      6'h2B:        return K_SW;
      6'h04:        return K_BEQ;
      default:      return K_J;
    endcase
  endfunction

  // One clock: drive inputs at the falling edge, sample settled outputs 2 time units later.
  task automatic tick(input logic rdy);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = rdy;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    #2;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_enables", enables(), 32'd0);
  endtask

  task automatic err_hold(input string tag);
    for (int i = 0; i < 3; i++) begin
      tick(i[0]);
      check({tag, "_state"}, 32'(dut.state), 32'(S_ERR));
      check({tag, "_illegal"}, 32'(illegal), 32'd1);
      check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
      check({tag, "_enables"}, enables(), 32'd0);
    end
  endtask

  // Runs one instruction to completion. Memory answers the fetch after wf wait
  // cycles and the data access after wm wait cycles; expectations follow from
  // the instruction class alone.
  task automatic run_instr(input logic [31:0] ins, input logic z, input int wf, input int wm);
    kind_t k = kind_of(ins);
    int cyc = 0, rw = 0, pcw = 0, pcwc = 0, irw = 0, req_c = 0, we_c = 0;
    int srca_c = 0, viol = 0, age = 0;
    int exp_cyc, exp_req;
    logic done = 1'b0, held_we = 1'b0, held_iord = 1'b0;
    logic [2:0] op_seen = '0, exp_op;
    logic [1:0] srcb_seen = '0, pcsrc_d = '0;
    logic regdst_d = 1'b0, mtr_d = 1'b0;
    logic [3:0] st_d = '0, exp_st;
    inst = ins;
    zero = z;
    st_q.delete();
    while (!done && cyc < 30) begin
      @(negedge clk);
      rst = 1'b0;
      mem_ready = 1'b0;
      #1;
      if (mem_req) begin
        if (age == 0) begin
          held_we = mem_we;
          held_iord = IorD;
        end else if (mem_we !== held_we || IorD !== held_iord) begin
          viol++;
        end
        if (age == (IorD ? wm : wf)) begin
          mem_ready = 1'b1;
          age = 0;
        end else begin
          age++;
        end
      end
      #1;
      cyc++;
      st_q.push_back(dut.state);
      if (mem_req && !mem_ready && enables() != 0) viol++;
      rw   += int'(RegWrite);
      pcw  += int'(PCWrite);
      pcwc += int'(PCWriteCond);
      irw  += int'(IRWrite);
      req_c += int'(mem_req);
      we_c  += int'(mem_we);
      if (ALUSrcA) begin
        srca_c++;
        op_seen = ALUOp;
        srcb_seen = ALUSrcB;
      end
      if (instr_done) begin
        done = 1'b1;
        regdst_d = RegDst;
        mtr_d = MemtoReg;
        pcsrc_d = PCSrc;
        st_d = dut.state;
      end
    end

    case (k)
      K_R:     begin exp_cyc = 4 + wf;      exp_st = S_WB_ALU; exp_op = r_alu(ins[5:0]); end
      K_I:     begin exp_cyc = 4 + wf;      exp_st = S_WB_ALU;
                     exp_op = (ins[31:26] == 6'h0D) ? ALU_OR : ALU_ADD; end
      K_LW:    begin exp_cyc = 5 + wf + wm; exp_st = S_WB_MEM; exp_op = ALU_ADD; end
      K_SW:    begin exp_cyc = 4 + wf + wm; exp_st = S_MEM_WR; exp_op = ALU_ADD; end
      K_BEQ:   begin exp_cyc = 3 + wf;      exp_st = S_BRANCH; exp_op = ALU_SUB; end
      default: begin exp_cyc = 3 + wf;      exp_st = S_JUMP;   exp_op = ALU_NOP; end
    endcase
    exp_req = wf + 1 + ((k == K_LW || k == K_SW) ? wm + 1 : 0);

    check("done_seen", 32'(done), 32'd1);
    check("first_state", 32'(st_q[0]), 32'(S_FETCH));
    check("cycles", 32'(cyc), 32'(exp_cyc));
    check("final_state", 32'(st_d), 32'(exp_st));
    check("regwrite_cnt", 32'(rw), (k == K_R || k == K_I || k == K_LW) ? 32'd1 : 32'd0);
    check("regdst", 32'(regdst_d), (k == K_R) ? 32'd1 : 32'd0);
    check("memtoreg", 32'(mtr_d), (k == K_LW) ? 32'd1 : 32'd0);
    check("irwrite_cnt", 32'(irw), 32'd1);
    check("pcwrite_cnt", 32'(pcw), (k == K_J) ? 32'd2 : 32'd1);
    check("pcwritecond_cnt", 32'(pcwc), (k == K_BEQ) ? 32'd1 : 32'd0);
    check("mem_req_cycles", 32'(req_c), 32'(exp_req));
    check("mem_we_cycles", 32'(we_c), (k == K_SW) ? 32'(wm + 1) : 32'd0);
    check("handshake_viol", 32'(viol), 32'd0);
    check("srca_cycles", 32'(srca_c), (k == K_J) ? 32'd0 : 32'd1);
    if (k != K_J) begin
      check("alu_op", 32'(op_seen), 32'(exp_op));
      check("alu_srcb", 32'(srcb_seen), (k == K_R || k == K_BEQ) ? 32'd0 : 32'd2);
    end
    if (k == K_BEQ || k == K_J) check("pcsrc", 32'(pcsrc_d), (k == K_BEQ) ? 32'd1 : 32'd2);
  endtask

  initial begin
    logic [5:0] functs [9];
    logic [31:0] ins;
    kind_t k;
    functs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h00};

    // Reset state: first cycle after reset is a FETCH request with no enables.
    do_reset();
    tick(1'b0);
    check("reset_state", 32'(dut.state), 32'(S_FETCH));
    check("reset_mem_req", 32'(mem_req), 32'd1);
    check("reset_iord", 32'(IorD), 32'd0);
    check("reset_srcb", 32'(ALUSrcB), 32'd1);
    check("reset_aluop", 32'(ALUOp), 32'(ALU_ADD));
    check("reset_enables", enables(), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);
    do_reset();

    run_instr(32'h00851020, 1'b0, 0, 0);
    check("add_st2", 32'(st_q[1]), 32'(S_DECODE));
    check("add_st3", 32'(st_q[2]), 32'(S_EX_R));
    run_instr(32'h8C820004, 1'b0, 0, 0);
    check("lw_st4", 32'(st_q[3]), 32'(S_MEM_RD));
    run_instr(32'hAC820004, 1'b0, 0, 3);
    check("sw_st6", 32'(st_q[5]), 32'(S_MEM_WR));
    run_instr(32'h10850003, 1'b1, 0, 0);
    run_instr(32'h08000010, 1'b0, 0, 0);
    run_instr(32'h00851020, 1'b0, 3, 0);
    run_instr(32'h8C820004, 1'b0, 3, 3);

    for (int n = 0; n < 40; n++) begin
      k = kind_t'($urandom_range(5));
      case (k)
        K_R:     ins = {6'h00, 20'($urandom), functs[$urandom_range(8)]};
        K_I:     ins = {($urandom_range(1) != 0) ? 6'h0D : 6'h08, 26'($urandom)};
        K_LW:    ins = {6'h23, 26'($urandom)};
        K_SW:    ins = {6'h2B, 26'($urandom)};
        K_BEQ:   ins = {6'h04, 26'($urandom)};
        default: ins = {6'h02, 26'($urandom)};
      endcase
      run_instr(ins, 1'($urandom), int'($urandom_range(3)), int'($urandom_range(3)));
    end

    // Unsupported opcode: DECODE -> ERR, sticky until reset.
    do_reset();
    inst = 32'hFC000000;
    tick(1'b1);
    tick(1'b0);
    check("badop_decode", 32'(dut.state), 32'(S_DECODE));
    err_hold("badop");
    do_reset();
    tick(1'b0);
    check("badop_rst_state", 32'(dut.state), 32'(S_FETCH));
    check("badop_rst_illegal", 32'(illegal), 32'd0);

    // Unsupported R-type funct: EX_R -> ERR.
    do_reset();
    inst = 32'h0000003F;
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    check("badfunct_exr", 32'(dut.state), 32'(S_EX_R));
    err_hold("badfunct");

    // Fetch never answered: four waiting cycles, then ERR.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      check("fetch_to_wait", 32'(dut.state), 32'(S_FETCH));
    end
    err_hold("fetch_to");

    // Load data access never answered: same bound in MEM_RD.
    do_reset();
    inst = 32'h8C820004;
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      check("rd_to_wait", 32'(dut.state), 32'(S_MEM_RD));
    end
    err_hold("rd_to");

    // Reset in the middle of a load access.
    do_reset();
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    check("midrd_state", 32'(dut.state), 32'(S_MEM_RD));
    check("midrd_iord", 32'(IorD), 32'd1);
    do_reset();
    tick(1'b0);
    check("midrd_after_state", 32'(dut.state), 32'(S_FETCH));
    check("midrd_after_iord", 32'(IorD), 32'd0);
    check("midrd_after_enables", enables(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
